// File: rtl/periferico_fifo_puertos.sv
// Pin-side FIFO peripheral: CPU pushes/pops bytes through output-pin toggles and polls status on input pins.
// Optional IRQ FSM with re-arm delay is built only when PERIF_FIFO_IRQ_EN is defined.
module periferico_fifo_puertos #(
   parameter int unsigned DEPTH      = 8,
   parameter int unsigned P_DATO_OUT = 1,
   parameter int unsigned P_CTRL     = 2,
   parameter int unsigned P_DATO_IN  = 1,
   parameter int unsigned P_ESTADO   = 2,
   parameter int unsigned IRQ_BIT    = 0,
   parameter int unsigned REARM      = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [127:0] salida_puertos,
   output logic [127:0] entrada_pines,
   output logic         irq,
   output logic [3:0]   cuenta
);

   localparam int unsigned   AW       = $clog2(DEPTH);
   localparam logic [AW-1:0] LAST     = AW'(DEPTH - 1);
   localparam logic [3:0]    FULL_CNT = 4'(DEPTH);

   logic [2:0]    ctrl, ctrl_q, ev;
   logic [7:0]    dato;
   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] head_q, head_d, tail_q, tail_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          ovf_q, ovf_d, unf_q, unf_d;
   logic          empty, full, push_ok, pop_ok;
   logic          unused_bus;

   assign ctrl  = salida_puertos[8*P_CTRL +: 3];
   assign dato  = salida_puertos[8*P_DATO_OUT +: 8];
   assign ev    = ctrl ^ ctrl_q;
   assign empty = (cnt_q == '0);
   assign full  = (cnt_q == FULL_CNT);

   // Both events judge pre-edge state; a full FIFO can still accept a push paired with a pop.
   assign pop_ok  = ev[1] && !empty;
   assign push_ok = ev[0] && (!full || pop_ok);

   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      cnt_d  = cnt_q + {3'b000, push_ok} - {3'b000, pop_ok};
      ovf_d  = ovf_q;
      unf_d  = unf_q;
      if (pop_ok)
         head_d = (head_q == LAST) ? '0 : head_q + 1'b1;
      if (push_ok)
         tail_d = (tail_q == LAST) ? '0 : tail_q + 1'b1;
      if (ev[2]) begin
         ovf_d = 1'b0;
         unf_d = 1'b0;
      end
      if (ev[0] && !push_ok)
         ovf_d = 1'b1;
      if (ev[1] && empty)
         unf_d = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctrl_q <= '0;
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= '0;
         ovf_q  <= 1'b0;
         unf_q  <= 1'b0;
         for (int unsigned i = 0; i < DEPTH; i++)
            mem_q[i] <= '0;
      end else begin
         ctrl_q <= ctrl;
         head_q <= head_d;
         tail_q <= tail_d;
         cnt_q  <= cnt_d;
         ovf_q  <= ovf_d;
         unf_q  <= unf_d;
         if (push_ok)
            mem_q[tail_q] <= dato;
      end
   end

`ifdef PERIF_FIFO_IRQ_EN
   typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_WAIT} irq_st_e;

   localparam logic [7:0] REARM_LD = 8'(REARM - 1);

   irq_st_e    st_q, st_d;
   logic [7:0] tmr_q, tmr_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st_q  <= ST_IDLE;
         tmr_q <= '0;
      end else begin
         st_q  <= st_d;
         tmr_q <= tmr_d;
      end
   end

   always_comb begin
      st_d  = st_q;
      tmr_d = tmr_q;
      case (st_q)
         ST_IDLE: if (!empty) st_d = ST_PEND;
         ST_PEND: if (pop_ok) begin
            st_d  = ST_WAIT;
            tmr_d = REARM_LD;
         end
         ST_WAIT: begin
            if (pop_ok)
               tmr_d = REARM_LD;
            else if (tmr_q == '0)
               st_d = empty ? ST_IDLE : ST_PEND;
            else
               tmr_d = tmr_q - 8'd1;
         end
         default: st_d = ST_IDLE;
      endcase
      if (cnt_d == '0)
         st_d = ST_IDLE;
   end

   assign irq        = (st_q == ST_PEND);
   assign unused_bus = ^salida_puertos;
`else
   assign irq        = 1'b0;
   assign unused_bus = ^{salida_puertos, 8'(REARM)};
`endif

   always_comb begin
      entrada_pines                    = '0;
      entrada_pines[8*P_DATO_IN +: 8]  = empty ? 8'h00 : mem_q[head_q];
      entrada_pines[8*P_ESTADO +: 8]   = {cnt_q, unf_q, ovf_q, full, empty};
      entrada_pines[IRQ_BIT]           = irq;
   end

   assign cuenta = cnt_q;

endmodule
